// File: rtl/vp_bbox_pkg.sv
// Shared widths, state encoding and accumulator init values for the
// bounding-box overlay stage.
package vp_bbox_pkg;

  localparam int XW_DEF = 11;
  localparam int YW_DEF = 11;
  localparam int CNT_W  = 16;

  typedef enum logic {
    ARMING = 1'b0,
    ACTIVE = 1'b1
  } bbox_state_t;

  localparam logic [CNT_W-1:0] CNT_INIT = '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

endpackage

// File: rtl/vp_frame_coords.sv
// Raster coordinate tracker: de/vsync edge detection plus saturating x/y
// counters that describe the pixel currently on the input.
module vp_frame_coords #(
  parameter int XW = 11,
  parameter int YW = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          de,
  input  logic          vsync,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          de_fall,
  output logic          vs_rise
);

  logic de_q;
  logic vs_q;

  assign de_fall = de_q & ~de;
  assign vs_rise = vsync & ~vs_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_q <= 1'b0;
      vs_q <= 1'b0;
      x    <= '0;
      y    <= '0;
    end else begin
      de_q <= de;
      vs_q <= vsync;

      // x is registered, so the first de cycle of a line still reads 0
      if (de) begin
        if (x != '1) x <= x + 1'b1;
      end else if (de_fall) begin
        x <= '0;
      end

      if (vs_rise) begin
        y <= '0;
      end else if (de_fall && (y != '1)) begin
        y <= y + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bbox_overlay.sv
// Per-frame foreground bounding-box tracker; the box found in one frame is
// latched at the next vsync rise and drawn over the following frame.
//
//   state  | meaning
//   ARMING | after reset; first vsync rise only clears the accumulators
//   ACTIVE | each vsync rise latches (or invalidates) the box, then clears
module bbox_overlay
  import vp_bbox_pkg::*;
#(
  parameter int          XW        = XW_DEF,
  parameter int          YW        = YW_DEF,
  parameter logic [7:0]  THRESH    = 8'd127,
  parameter int          MIN_COUNT = 16,
  parameter logic [23:0] BOX_COLOR = 24'hFF0000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          de,
  input  logic          hsync,
  input  logic          vsync,
  input  logic [23:0]   pixel_in,
  output logic          de_out,
  output logic          hsync_out,
  output logic          vsync_out,
  output logic [23:0]   pixel_out,
  output logic          box_valid,
  output logic [XW-1:0] x_min,
  output logic [XW-1:0] x_max,
  output logic [YW-1:0] y_min,
  output logic [YW-1:0] y_max
);

  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_COUNT);

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          de_fall;
  logic          vs_rise;

  vp_frame_coords #(.XW(XW), .YW(YW)) u_coords (
    .clk     (clk),
    .rst_n   (rst_n),
    .de      (de),
    .vsync   (vsync),
    .x       (x),
    .y       (y),
    .de_fall (de_fall),
    .vs_rise (vs_rise)
  );

  logic             fg;
  logic [XW-1:0]    ax_min, ax_max, ax_min_upd, ax_max_upd;
  logic [YW-1:0]    ay_min, ay_max, ay_min_upd, ay_max_upd;
  logic [CNT_W-1:0] cnt, cnt_upd;
  bbox_state_t      state_q, state_d;
  logic             acc_clr;
  logic             latch;
  logic             hit;

  assign fg = de & (pixel_in[15:8] > THRESH);

  // Post-update values, so a foreground pixel coincident with vsync rise
  // still lands in the frame being closed.
  always_comb begin
    ax_min_upd = ax_min;
    ax_max_upd = ax_max;
    ay_min_upd = ay_min;
    ay_max_upd = ay_max;
    cnt_upd    = cnt;
    if (fg) begin
      if (x < ax_min) ax_min_upd = x;
      if (x > ax_max) ax_max_upd = x;
      if (y < ay_min) ay_min_upd = y;
      if (y > ay_max) ay_max_upd = y;
      if (cnt != CNT_MAX) cnt_upd = cnt + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_clr = 1'b0;
    latch   = 1'b0;
    case (state_q)
      ARMING: if (vs_rise) begin
        acc_clr = 1'b1;
        state_d = ACTIVE;
      end
      ACTIVE: if (vs_rise) begin
        acc_clr = 1'b1;
        latch   = 1'b1;
      end
      default: state_d = ARMING;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARMING;
      ax_min    <= '1;
      ax_max    <= '0;
      ay_min    <= '1;
      ay_max    <= '0;
      cnt       <= CNT_INIT;
      box_valid <= 1'b0;
      x_min     <= '0;
      x_max     <= '0;
      y_min     <= '0;
      y_max     <= '0;
    end else begin
      state_q <= state_d;
      if (acc_clr) begin
        ax_min <= '1;
        ax_max <= '0;
        ay_min <= '1;
        ay_max <= '0;
        cnt    <= CNT_INIT;
      end else begin
        ax_min <= ax_min_upd;
        ax_max <= ax_max_upd;
        ay_min <= ay_min_upd;
        ay_max <= ay_max_upd;
        cnt    <= cnt_upd;
      end
      if (latch) begin
        if (cnt_upd >= MIN_CNT) begin
          box_valid <= 1'b1;
          x_min     <= ax_min_upd;
          x_max     <= ax_max_upd;
          y_min     <= ay_min_upd;
          y_max     <= ay_max_upd;
        end else begin
          box_valid <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    hit = box_valid &
          ((((x == x_min) | (x == x_max)) & (y >= y_min) & (y <= y_max)) |
           (((y == y_min) | (y == y_max)) & (x >= x_min) & (x <= x_max)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_out    <= 1'b0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      pixel_out <= '0;
    end else begin
      de_out    <= de;
      hsync_out <= hsync;
      vsync_out <= vsync;
      pixel_out <= de ? (hit ? BOX_COLOR : pixel_in) : 24'h000000;
    end
  end

endmodule

// File: tb/tb_bbox_overlay.sv
// Directed bench for bbox_overlay: 64x64 active frames, 83-cycle lines,
// one vsync line per frame; every expected value is hand-derived.
module tb_bbox_overlay;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        de, hsync, vsync;
  logic [23:0] pixel_in;
  logic        de_out, hsync_out, vsync_out;
  logic [23:0] pixel_out;
  logic        box_valid;
  logic [10:0] x_min, x_max;
  logic [10:0] y_min, y_max;

  bbox_overlay dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .de        (de),
    .hsync     (hsync),
    .vsync     (vsync),
    .pixel_in  (pixel_in),
    .de_out    (de_out),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out),
    .pixel_out (pixel_out),
    .box_valid (box_valid),
    .x_min     (x_min),
    .x_max     (x_max),
    .y_min     (y_min),
    .y_max     (y_max)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int align_err = 0;
  logic p_de = 1'b0, p_hs = 1'b0, p_vs = 1'b0;
  int p_x = 0, p_y = 0;
  logic [23:0] out_img [0:63][0:63];

  function automatic logic [23:0] pix(input int kind, input int x, input int y);
    case (kind)
      1: return (x >= 10 && x <= 17 && y >= 20 && y <= 27) ? 24'hFFFFFF : 24'h000000;
      2: begin
        if (y == 5 && x < 15) return 24'hFFFFFF;
        else if (y == 6 && x == 0) return 24'h007F00;
        else return 24'h123456;
      end
      3: return ((x == 0 && y == 0) || (x == 63 && y == 63) ||
                 (y == 32 && x >= 20 && x <= 33)) ? 24'h00FF00 : 24'h000000;
      4: return (y == 10 && x >= 20 && x <= 35) ? 24'h008000 : 24'h000000;
      default: return 24'h000000;
    endcase
  endfunction

  // One clock: capture outputs produced by the previous inputs, then drive new ones.
  task automatic step(input logic d, input logic h, input logic v,
                      input logic [23:0] p, input int x, input int y);
    @(posedge clk); #1;
    if (p_de && p_x >= 0 && p_x < 64 && p_y >= 0 && p_y < 64) out_img[p_y][p_x] = pixel_out;
    if ({de_out, hsync_out, vsync_out} !== {p_de, p_hs, p_vs}) align_err++;
    de = d; hsync = h; vsync = v; pixel_in = p;
    p_de = d; p_hs = h; p_vs = v; p_x = x; p_y = y;
  endtask

  task automatic send_lines(input int kind, input int y0, input int y1);
    for (int yy = y0; yy <= y1; yy++)
      for (int i = 0; i < 83; i++)
        step(i < 64, i >= 70 && i < 76, 1'b0, (i < 64) ? pix(kind, i, yy) : 24'h0, i, yy);
  endtask

  task automatic send_vsync();
    for (int i = 0; i < 83; i++)
      step(1'b0, i >= 70 && i < 76, i < 3, 24'h0, 0, 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; de = 0; hsync = 0; vsync = 0; pixel_in = 24'h0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({de_out, hsync_out, vsync_out, box_valid} !== 4'b0000) begin
      n_err++; $display("FAIL reset_ctrl got %b want 0000", {de_out, hsync_out, vsync_out, box_valid});
    end
    n_cmp++;
    if (pixel_out !== 24'h0) begin
      n_err++; $display("FAIL reset_pixel got %h want 000000", pixel_out);
    end
    n_cmp++;
    if ({x_min, x_max, y_min, y_max} !== 44'h0) begin
      n_err++; $display("FAIL reset_box got %0d %0d %0d %0d want 0 0 0 0", x_min, x_max, y_min, y_max);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_square();
    align_err = 0;
    send_vsync();
    send_lines(1, 0, 63);
    n_cmp++;
    if (box_valid !== 1'b0) begin
      n_err++; $display("FAIL arm_no_box got %b want 0", box_valid);
    end
    send_vsync();
    n_cmp++;
    if ({box_valid, x_min, x_max, y_min, y_max} !== {1'b1, 11'd10, 11'd17, 11'd20, 11'd27}) begin
      n_err++; $display("FAIL square_box got v=%b %0d %0d %0d %0d want v=1 10 17 20 27",
                        box_valid, x_min, x_max, y_min, y_max);
    end
    n_cmp++;
    if (align_err !== 0) begin
      n_err++; $display("FAIL square_align got %0d misaligned cycles want 0", align_err);
    end
  endtask

  task automatic test_overlay();
    send_lines(0, 0, 63);
    n_cmp++;
    if (out_img[22][10] !== 24'hFF0000) begin
      n_err++; $display("FAIL ovl_10_22 got %h want ff0000", out_img[22][10]);
    end
    n_cmp++;
    if (out_img[20][13] !== 24'hFF0000) begin
      n_err++; $display("FAIL ovl_13_20 got %h want ff0000", out_img[20][13]);
    end
    n_cmp++;
    if (out_img[22][12] !== 24'h000000) begin
      n_err++; $display("FAIL ovl_12_22 got %h want 000000", out_img[22][12]);
    end
    n_cmp++;
    if (out_img[27][17] !== 24'hFF0000) begin
      n_err++; $display("FAIL ovl_17_27 got %h want ff0000", out_img[27][17]);
    end
    n_cmp++;
    if ({out_img[19][10], out_img[22][9], out_img[28][13]} !== 72'h0) begin
      n_err++; $display("FAIL ovl_outside got %h %h %h want 000000 x3",
                        out_img[19][10], out_img[22][9], out_img[28][13]);
    end
  endtask

  task automatic test_below_thresh();
    int diffs;
    send_vsync();
    n_cmp++;
    if (box_valid !== 1'b0) begin
      n_err++; $display("FAIL empty_frame_valid got %b want 0", box_valid);
    end
    align_err = 0;
    send_lines(2, 0, 63);
    diffs = 0;
    for (int yy = 0; yy < 64; yy++)
      for (int xx = 0; xx < 64; xx++)
        if (out_img[yy][xx] !== pix(2, xx, yy)) diffs++;
    n_cmp++;
    if (diffs !== 0) begin
      n_err++; $display("FAIL passthrough got %0d differing pixels want 0", diffs);
    end
    send_vsync();
    n_cmp++;
    if ({box_valid, x_min, x_max, y_min, y_max} !== {1'b0, 11'd10, 11'd17, 11'd20, 11'd27}) begin
      n_err++; $display("FAIL below_count got v=%b %0d %0d %0d %0d want v=0 10 17 20 27",
                        box_valid, x_min, x_max, y_min, y_max);
    end
    n_cmp++;
    if (align_err !== 0) begin
      n_err++; $display("FAIL below_align got %0d misaligned cycles want 0", align_err);
    end
  endtask

  task automatic test_full_extent();
    send_lines(3, 0, 63);
    send_vsync();
    n_cmp++;
    if ({box_valid, x_min, x_max, y_min, y_max} !== {1'b1, 11'd0, 11'd63, 11'd0, 11'd63}) begin
      n_err++; $display("FAIL full_extent got v=%b %0d %0d %0d %0d want v=1 0 63 0 63",
                        box_valid, x_min, x_max, y_min, y_max);
    end
  endtask

  task automatic test_reset_mid();
    send_lines(1, 0, 29);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 24'hFFFFFF, i, 30);
    n_cmp++;
    if ({de_out, hsync_out, pixel_out} !== {1'b1, 1'b1, 24'hFFFFFF}) begin
      n_err++; $display("FAIL pre_reset_stream got %b %b %h want 1 1 ffffff", de_out, hsync_out, pixel_out);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({de_out, hsync_out, vsync_out, box_valid, pixel_out, x_min, x_max, y_min, y_max} !== 72'h0) begin
      n_err++; $display("FAIL midreset_zero got de=%b hs=%b vs=%b v=%b px=%h box=%0d %0d %0d %0d want all 0",
                        de_out, hsync_out, vsync_out, box_valid, pixel_out, x_min, x_max, y_min, y_max);
    end
    de = 0; hsync = 0; vsync = 0; pixel_in = 24'h0;
    p_de = 0; p_hs = 0; p_vs = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    send_lines(1, 0, 63);
    send_vsync();
    n_cmp++;
    if ({box_valid, x_min, x_max, y_min, y_max} !== 45'h0) begin
      n_err++; $display("FAIL rearm_no_latch got v=%b %0d %0d %0d %0d want v=0 0 0 0 0",
                        box_valid, x_min, x_max, y_min, y_max);
    end
    send_lines(1, 0, 63);
    send_vsync();
    n_cmp++;
    if ({box_valid, x_min, x_max, y_min, y_max} !== {1'b1, 11'd10, 11'd17, 11'd20, 11'd27}) begin
      n_err++; $display("FAIL after_reset_box got v=%b %0d %0d %0d %0d want v=1 10 17 20 27",
                        box_valid, x_min, x_max, y_min, y_max);
    end
  endtask

  task automatic test_same_cycle();
    send_lines(4, 0, 62);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 24'h0, i, 63);
    step(1'b1, 1'b0, 1'b1, 24'hFFFFFF, 5, 63);
    repeat (10) step(1'b0, 1'b0, 1'b1, 24'h0, 0, 0);
    repeat (10) step(1'b0, 1'b0, 1'b0, 24'h0, 0, 0);
    n_cmp++;
    if ({box_valid, x_min, x_max, y_min, y_max} !== {1'b1, 11'd5, 11'd35, 11'd10, 11'd63}) begin
      n_err++; $display("FAIL same_cycle_box got v=%b %0d %0d %0d %0d want v=1 5 35 10 63",
                        box_valid, x_min, x_max, y_min, y_max);
    end
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_square();
    test_overlay();
    test_below_thresh();
    test_full_extent();
    test_reset_mid();
    test_same_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bbox_overlay.md
# bbox_overlay

Per-frame bounding-box tracker and overlay stage placed directly downstream of `median5x5` in the video pipeline. It consumes the filtered pixel stream with its `de`/`hsync`/`vsync` timing, finds the extent of foreground pixels in each frame, and latches the box at the start of the next frame. It then draws that box in `BOX_COLOR` on the passing stream and forwards the stream to the HDMI output with fixed one-cycle latency.

## Interface
Parameters:
- `XW`, 11, x-coordinate / counter width
- `YW`, 11, y-coordinate width
- `THRESH`, 8'd127, foreground when `pixel_in[15:8] > THRESH`
- `MIN_COUNT`, 16, minimum foreground pixels for a valid box
- `BOX_COLOR`, 24'hFF0000, overlay colour {R,G,B}

Ports:
- `clk`  in  1  pixel clock; the only clock
- `rst_n`  in  1  asynchronous, active-low reset
- `de`  in  1  data enable, active high
- `hsync`  in  1  horizontal sync, passed through
- `vsync`  in  1  vertical sync, active high
- `pixel_in`  in  24  {R,G,B} from the median stage
- `de_out`, `hsync_out`, `vsync_out`  out  1 each  inputs delayed by 1 cycle
- `pixel_out`  out  24  overlaid pixel, delayed by 1 cycle
- `box_valid`  out  1  the latched box is valid
- `x_min`, `x_max`  out  XW  latched box, inclusive
- `y_min`, `y_max`  out  YW  latched box, inclusive

## Operation
- **Coordinates.** `x` increments on each `de` cycle and saturates at all-ones. It clears on the `de` falling edge. `y` increments on the `de` falling edge, saturates, and clears on the `vsync` rising edge. The pixel at the first `de` cycle of a line has `x` = 0.
- **Foreground.** A pixel is foreground when `fg = de & (pixel_in[15:8] > THRESH)`.
- **Accumulators.** While `fg`:
  - `ax_min`/`ay_min` take the smaller value; `ax_max`/`ay_max` take the larger.
  - `cnt` increments and saturates at `2^16-1`.
  - Init values: mins all-ones, maxes 0, `cnt` 0.
- **State machine: ARMING → ACTIVE.**
  - Reset enters ARMING.
  - On the first `vsync` rise in ARMING: clear accumulators, go to ACTIVE. No latch occurs, so a partial frame never produces a box.
  - On each `vsync` rise in ACTIVE: latch the box.
    - If `cnt` ≥ `MIN_COUNT`: load `x_min..y_max` from the accumulators and set `box_valid` = 1.
    - Otherwise: set `box_valid` = 0 and hold the box registers.
    - Then clear the accumulators.
- **Simultaneous events.** If `fg` and the `vsync` rise occur in the same cycle, the pixel belongs to the closing frame. The latch uses the post-update accumulator values.
- **Overlay.** When `de` & `box_valid` and either condition holds, `pixel_out` = `BOX_COLOR`; otherwise `pixel_out` = `pixel_in`:
  - (`x`==`x_min` | `x`==`x_max`) & `y_min`≤`y`≤`y_max`
  - (`y`==`y_min` | `y`==`y_max`) & `x_min`≤`x`≤`x_max`
- **Output zeroing.** `pixel_out` is 0 whenever `de` is low.
- **Comparisons** are unsigned.

## Timing
- **Latency.** Every stream output is registered, with exactly 1 cycle from input to output. `de`/`hsync`/`vsync`/`pixel` stay mutually aligned.
- **Box outputs** update in the cycle after the `vsync` rise is sampled. They then stay stable for the whole following frame.
- **Edge detection** uses registered `de` and `vsync`, with no added stream latency.
- **Reset values.** All outputs are 0 and `box_valid` is 0. Box registers are 0. Accumulators are at their init values. `x`, `y` and edge registers are 0. State is ARMING.
- **Mid-frame reset** takes effect immediately, because reset is asynchronous. The first `vsync` after release only arms.

## Structure
- **Package `vp_bbox_pkg`:**
  - `XW`/`YW` defaults and the `CNT_W` = 16 constant.
  - State encoding (ARMING, ACTIVE).
  - Accumulator init constants.
- **Sub-module `vp_frame_coords`** holds the `de`/`vsync` edge detection and the `x`/`y` counters. It outputs `x`, `y`, `de_fall` and `vs_rise`.
- **Top level** holds the accumulators, FSM, box registers and overlay mux.

## Test plan
Frames are 64×64 active with `H_SIZE` 83, `hdmi_in`-style timing. Each case includes one arming frame after reset.
1. **Square.** An 8×8 foreground square (`pixel` 24'hFFFFFF) at x 10..17, y 20..27 → after the next `vsync` rise: `box_valid` = 1, box = 10, 17, 20, 27.
2. **Overlay.** The following frame is all 24'h000000 → pixels at (10,22) and (13,20) output 24'hFF0000 one cycle later; (12,22) outputs 24'h000000.
3. **Below threshold count.** A frame with 15 foreground pixels (< `MIN_COUNT`) → `box_valid` = 0, `pixel_out` equals `pixel_in` delayed by 1 cycle, and the box registers are unchanged.
4. **Full-frame extent.** Corner pixels (0,0) and (63,63) plus 14 others → box = 0, 63, 0, 63.
5. **Reset mid-frame.** Assert `rst_n` low mid-frame → all outputs 0 immediately. The next `vsync` rise leaves `box_valid` = 0 with no latch. The following frame with the square from test 1 latches 10, 17, 20, 27.
6. **Same-cycle foreground and vsync.** Force a `fg` pixel at x = 5 in the same cycle as the `vsync` rise → `x_min` = 5 in the latched box.
